// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding and RV32 major opcodes.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_mux.sv
// Per-read-port operand forwarding mux, EX > MEM > WB > register file priority.
// Latency: combinational; no backpressure, pure select logic.
module pipe_hazard_ctrl_fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rren,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_wr,
    input  logic [XLEN-1:0]   ex_alu,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic [XLEN-1:0]   mem_alu,
    input  logic [XLEN-1:0]   mem_dm,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_wr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic              ex_match,
    output logic [XLEN-1:0]   operand
);

    logic rd_live;
    logic mem_match;
    logic wb_match;

    // x0 reads are hardwired zero in the register file, so they never forward
    assign rd_live   = rren && (rs != '0);
    assign ex_match  = rd_live && (rs == ex_wr);
    assign mem_match = rd_live && (rs == mem_wr) && mem_valid && mem_wen;
    assign wb_match  = rd_live && (rs == wb_wr) && wb_valid && wb_wen;

    always_comb begin
        operand = rf_rdata;
        if (ex_match && ex_valid && ex_wen && !ex_is_load) begin
            operand = ex_alu;
        end else if (mem_match) begin
            operand = mem_is_load ? mem_dm : mem_alu;
        end else if (wb_match) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard control: forwarding, load-use bubbles, DM-wait freeze, branch flush.
// Latency: fwd_data combinational, state/counters next edge; DM stall freezes the pipe until dm_rvalid.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_RD   = 2,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*REG_AW-1:0] id_rs,
    input  logic [NUM_RD-1:0]        id_rren,
    input  logic [NUM_RD*XLEN-1:0]   rf_rdata,
    input  logic                     ex_valid,
    input  logic                     mem_valid,
    input  logic                     wb_valid,
    input  logic [REG_AW-1:0]        ex_wr,
    input  logic [REG_AW-1:0]        mem_wr,
    input  logic [REG_AW-1:0]        wb_wr,
    input  logic                     ex_wen,
    input  logic                     mem_wen,
    input  logic                     wb_wen,
    input  logic                     ex_is_load,
    input  logic                     mem_is_load,
    input  logic [XLEN-1:0]          ex_alu,
    input  logic [XLEN-1:0]          mem_alu,
    input  logic [XLEN-1:0]          mem_dm,
    input  logic                     dm_rvalid,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     ex_br_taken,
    output logic [NUM_RD*XLEN-1:0]   fwd_data,
    output logic                     stall_front,
    output logic                     bubble_ex,
    output logic                     freeze,
    output logic                     flush,
    output logic                     err_timeout,
    output logic [CNT_W-1:0]         cnt_stall,
    output logic [CNT_W-1:0]         cnt_lu,
    output logic [CNT_W-1:0]         cnt_flush
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WCW-1:0]    wait_cnt;
    logic [NUM_RD-1:0] ex_match;
    logic              load_use;
    logic              mem_wait;
    logic              waiting;
    logic              wait_enter;
    logic              stall_c;
    logic              bubble_c;
    logic              freeze_c;
    logic              flush_c;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        pipe_hazard_ctrl_fwd_mux #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW)
        ) u_fwd (
            .rs          (id_rs[i*REG_AW +: REG_AW]),
            .rren        (id_rren[i]),
            .ex_valid    (ex_valid),
            .ex_wen      (ex_wen),
            .ex_is_load  (ex_is_load),
            .ex_wr       (ex_wr),
            .ex_alu      (ex_alu),
            .mem_valid   (mem_valid),
            .mem_wen     (mem_wen),
            .mem_is_load (mem_is_load),
            .mem_wr      (mem_wr),
            .mem_alu     (mem_alu),
            .mem_dm      (mem_dm),
            .wb_valid    (wb_valid),
            .wb_wen      (wb_wen),
            .wb_wr       (wb_wr),
            .wb_data     (wb_data),
            .rf_rdata    (rf_rdata[i*XLEN +: XLEN]),
            .ex_match    (ex_match[i]),
            .operand     (fwd_data[i*XLEN +: XLEN])
        );
    end

    assign load_use   = ex_valid && ex_is_load && ex_wen && (|ex_match);
    assign mem_wait   = mem_valid && mem_is_load && !dm_rvalid;
    assign waiting    = (state == MEM_WAIT) && !dm_rvalid;
    assign wait_enter = (state == RUN) && mem_wait;

    // The dm_rvalid cycle in MEM_WAIT is decoded exactly like RUN, so a held branch flushes there
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        freeze_c  = 1'b0;
        flush_c   = 1'b0;
        if (waiting || mem_wait) begin
            freeze_c  = 1'b1;
            stall_c   = 1'b1;
            state_nxt = MEM_WAIT;
        end else begin
            state_nxt = RUN;
            if (ex_br_taken) begin
                flush_c = 1'b1;
            end else if (load_use) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
        end
    end

    assign stall_front = rst && stall_c;
    assign bubble_ex   = rst && bubble_c;
    assign freeze      = rst && freeze_c;
    assign flush       = rst && flush_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            cnt_stall   <= '0;
            cnt_lu      <= '0;
            cnt_flush   <= '0;
        end else begin
            state <= state_nxt;
            if (wait_enter) begin
                wait_cnt <= '0;
            end else if (waiting && wait_cnt != WCW'(WAIT_MAX)) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
            // Sticky; the FSM keeps waiting for the DM after flagging
            if (waiting && wait_cnt == WCW'(WAIT_MAX - 1)) begin
                err_timeout <= 1'b1;
            end
            if (stall_c && cnt_stall != {CNT_W{1'b1}}) cnt_stall <= cnt_stall + CNT_W'(1);
            if (bubble_c && cnt_lu != {CNT_W{1'b1}}) cnt_lu <= cnt_lu + CNT_W'(1);
            if (flush_c && cnt_flush != {CNT_W{1'b1}}) cnt_flush <= cnt_flush + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_RD   = 2;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*REG_AW-1:0] id_rs;
    logic [NUM_RD-1:0]        id_rren;
    logic [NUM_RD*XLEN-1:0]   rf_rdata;
    logic                     ex_valid, mem_valid, wb_valid;
    logic [REG_AW-1:0]        ex_wr, mem_wr, wb_wr;
    logic                     ex_wen, mem_wen, wb_wen;
    logic                     ex_is_load, mem_is_load;
    logic [XLEN-1:0]          ex_alu, mem_alu, mem_dm, wb_data;
    logic                     dm_rvalid, ex_br_taken;
    logic [NUM_RD*XLEN-1:0]   fwd_data;
    logic                     stall_front, bubble_ex, freeze, flush, err_timeout;
    logic [CNT_W-1:0]         cnt_stall, cnt_lu, cnt_flush;

    int tests  = 0;
    int failed = 0;

    bit m_waiting;
    int m_run;
    bit m_err;
    int m_stall, m_lu, m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_RD(NUM_RD), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rren(id_rren), .rf_rdata(rf_rdata),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
        .ex_alu(ex_alu), .mem_alu(mem_alu), .mem_dm(mem_dm), .dm_rvalid(dm_rvalid),
        .wb_data(wb_data), .ex_br_taken(ex_br_taken), .fwd_data(fwd_data),
        .stall_front(stall_front), .bubble_ex(bubble_ex), .freeze(freeze), .flush(flush),
        .err_timeout(err_timeout), .cnt_stall(cnt_stall), .cnt_lu(cnt_lu), .cnt_flush(cnt_flush)
    );

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] model_operand(int p);
        logic [REG_AW-1:0] rs;
        rs = id_rs[p*REG_AW +: REG_AW];
        if (id_rren[p] && rs != 0) begin
            if (ex_valid && ex_wen && !ex_is_load && ex_wr == rs) return ex_alu;
            if (mem_valid && mem_wen && mem_wr == rs) return mem_is_load ? mem_dm : mem_alu;
            if (wb_valid && wb_wen && wb_wr == rs) return wb_data;
        end
        return rf_rdata[p*XLEN +: XLEN];
    endfunction

    function automatic logic [NUM_RD*XLEN-1:0] exp_fwd();
        logic [NUM_RD*XLEN-1:0] v;
        v = '0;
        for (int p = 0; p < NUM_RD; p++) v[p*XLEN +: XLEN] = model_operand(p);
        return v;
    endfunction

    function automatic bit model_load_use();
        bit hit;
        hit = 0;
        for (int p = 0; p < NUM_RD; p++)
            if (id_rren[p] && id_rs[p*REG_AW +: REG_AW] != 0 && id_rs[p*REG_AW +: REG_AW] == ex_wr)
                hit = 1;
        return ex_valid && ex_is_load && ex_wen && hit;
    endfunction

    // {stall_front, bubble_ex, freeze, flush}
    function automatic logic [3:0] exp_ctrl();
        bit dm_stall;
        dm_stall = !dm_rvalid && (m_waiting || (mem_valid && mem_is_load));
        if (!rst) return 4'b0000;
        if (dm_stall) return 4'b1010;
        if (ex_br_taken) return 4'b0001;
        if (model_load_use()) return 4'b1100;
        return 4'b0000;
    endfunction

    function automatic logic [3*CNT_W:0] exp_cnts();
        return {CNT_W'(m_stall), CNT_W'(m_lu), CNT_W'(m_flush), m_err};
    endfunction

    task automatic model_clear();
        m_waiting = 0; m_run = 0; m_err = 0;
        m_stall = 0; m_lu = 0; m_flush = 0;
    endtask

    // Advance the model by one clock using the inputs now applied, then move to posedge+1.
    task automatic tick();
        logic [3:0] c;
        c = exp_ctrl();
        if (rst) begin
            if (c[1]) begin
                m_run++;
                if (m_run > WAIT_MAX) m_err = 1;
            end else begin
                m_run = 0;
            end
            m_waiting = c[1];
            if (c[3] && m_stall < CNT_MAX) m_stall++;
            if (c[2] && m_lu < CNT_MAX) m_lu++;
            if (c[0] && m_flush < CNT_MAX) m_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rren = '0; rf_rdata = '0;
        ex_valid = 0; mem_valid = 0; wb_valid = 0;
        ex_wr = '0; mem_wr = '0; wb_wr = '0;
        ex_wen = 0; mem_wen = 0; wb_wen = 0;
        ex_is_load = 0; mem_is_load = 0;
        ex_alu = '0; mem_alu = '0; mem_dm = '0; wb_data = '0;
        dm_rvalid = 0; ex_br_taken = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        idle();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic set_mem_load(logic [REG_AW-1:0] wr);
        mem_valid = 1; mem_wen = 1; mem_is_load = 1; mem_wr = wr;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 0;
        idle();
        set_mem_load(5'd3);
        ex_br_taken = 1;
        #2;
        tests++;
        if ({stall_front, bubble_ex, freeze, flush} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_ctrl got %b want 0000", {stall_front, bubble_ex, freeze, flush});
        end
        tests++;
        if ({cnt_stall, cnt_lu, cnt_flush, err_timeout} !== '0) begin
            failed++;
            $display("FAIL reset_cnts got %h/%h/%h err=%b want all 0", cnt_stall, cnt_lu, cnt_flush, err_timeout);
        end
        apply_reset();
    endtask

    task automatic test_forward_ex();
        apply_reset();
        ex_valid = 1; ex_wen = 1; ex_wr = 5'd5; ex_alu = 32'h11;
        id_rs = {5'd5, 5'd5}; id_rren = 2'b11;
        rf_rdata = {32'hDEAD_0001, 32'hDEAD_0000};
        #2;
        tests++;
        if (fwd_data !== {32'h11, 32'h11}) begin
            failed++;
            $display("FAIL fwd_ex got %h want %h", fwd_data, {32'h11, 32'h11});
        end
        tests++;
        if ({stall_front, bubble_ex, freeze, flush} !== 4'b0000) begin
            failed++;
            $display("FAIL fwd_ex_ctrl got %b want 0000", {stall_front, bubble_ex, freeze, flush});
        end
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_wr = 5'd7;
        id_rs = {5'd0, 5'd7}; id_rren = 2'b01;
        #2;
        tests++;
        if ({stall_front, bubble_ex, freeze, flush} !== 4'b1100) begin
            failed++;
            $display("FAIL lu_ctrl got %b want 1100", {stall_front, bubble_ex, freeze, flush});
        end
        tick();
        tests++;
        if (cnt_lu !== CNT_W'(1) || cnt_stall !== CNT_W'(1)) begin
            failed++;
            $display("FAIL lu_cnt got lu=%0d stall=%0d want 1/1", cnt_lu, cnt_stall);
        end
        ex_valid = 0; ex_is_load = 0; ex_wen = 0;
        set_mem_load(5'd7);
        mem_dm = 32'hAB; mem_alu = 32'h55; dm_rvalid = 1;
        #2;
        tests++;
        if (fwd_data[XLEN-1:0] !== 32'hAB) begin
            failed++;
            $display("FAIL lu_dm_fwd got %h want 000000ab", fwd_data[XLEN-1:0]);
        end
        tests++;
        if ({stall_front, bubble_ex, freeze, flush} !== 4'b0000) begin
            failed++;
            $display("FAIL lu_after_ctrl got %b want 0000", {stall_front, bubble_ex, freeze, flush});
        end
        tick();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        set_mem_load(5'd3);
        for (int i = 0; i < 3; i++) begin
            #2;
            tests++;
            if ({stall_front, bubble_ex, freeze, flush} !== 4'b1010) begin
                failed++;
                $display("FAIL wait_ctrl[%0d] got %b want 1010", i, {stall_front, bubble_ex, freeze, flush});
            end
            tick();
        end
        dm_rvalid = 1;
        #2;
        tests++;
        if ({stall_front, bubble_ex, freeze, flush} !== 4'b0000) begin
            failed++;
            $display("FAIL wait_release got %b want 0000", {stall_front, bubble_ex, freeze, flush});
        end
        tick();
        tests++;
        if (cnt_stall !== CNT_W'(3) || err_timeout !== 1'b0) begin
            failed++;
            $display("FAIL wait_cnt got stall=%0d err=%b want 3/0", cnt_stall, err_timeout);
        end
        idle();
        #2;
        tests++;
        if (freeze !== 1'b0) begin
            failed++;
            $display("FAIL wait_back_run got freeze=%b want 0", freeze);
        end
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        set_mem_load(5'd4);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                #2;
                tests++;
                if (err_timeout !== 1'b0) begin
                    failed++;
                    $display("FAIL tmo_early got err=%b want 0 after 15 cycles", err_timeout);
                end
            end
            tick();
        end
        #2;
        tests++;
        if (err_timeout !== 1'b1 || freeze !== 1'b1) begin
            failed++;
            $display("FAIL tmo_set got err=%b freeze=%b want 1/1", err_timeout, freeze);
        end
        dm_rvalid = 1;
        tick();
        idle();
        tick();
        #2;
        tests++;
        if (err_timeout !== 1'b1 || freeze !== 1'b0) begin
            failed++;
            $display("FAIL tmo_sticky got err=%b freeze=%b want 1/0", err_timeout, freeze);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_wr = 5'd7;
        id_rs = {5'd7, 5'd2}; id_rren = 2'b11; ex_br_taken = 1;
        #2;
        tests++;
        if ({stall_front, bubble_ex, freeze, flush} !== 4'b0001) begin
            failed++;
            $display("FAIL br_over_lu got %b want 0001", {stall_front, bubble_ex, freeze, flush});
        end
        tick();
        ex_valid = 0; ex_is_load = 0; ex_wen = 0;
        set_mem_load(5'd6);
        for (int i = 0; i < 2; i++) begin
            #2;
            tests++;
            if ({stall_front, bubble_ex, freeze, flush} !== 4'b1010) begin
                failed++;
                $display("FAIL br_in_wait[%0d] got %b want 1010", i, {stall_front, bubble_ex, freeze, flush});
            end
            tick();
        end
        dm_rvalid = 1;
        #2;
        tests++;
        if ({stall_front, bubble_ex, freeze, flush} !== 4'b0001) begin
            failed++;
            $display("FAIL br_release got %b want 0001", {stall_front, bubble_ex, freeze, flush});
        end
        tick();
        tests++;
        if (cnt_flush !== CNT_W'(2) || cnt_lu !== CNT_W'(0)) begin
            failed++;
            $display("FAIL br_cnt got flush=%0d lu=%0d want 2/0", cnt_flush, cnt_lu);
        end
        idle();
    endtask

    task automatic test_x0_priority();
        apply_reset();
        ex_valid = 1; mem_valid = 1; wb_valid = 1;
        ex_wen = 1; mem_wen = 1; wb_wen = 1;
        ex_alu = 32'hA1; mem_alu = 32'hB2; wb_data = 32'hC3; mem_dm = 32'hD4;
        id_rs = '0; id_rren = 2'b11;
        #2;
        tests++;
        if (fwd_data !== '0) begin
            failed++;
            $display("FAIL x0_fwd got %h want 0", fwd_data);
        end
        ex_wr = 5'd9; mem_wr = 5'd9; wb_wr = 5'd9; id_rs = {5'd9, 5'd9};
        #2;
        tests++;
        if (fwd_data !== {32'hA1, 32'hA1}) begin
            failed++;
            $display("FAIL prio_ex got %h want %h", fwd_data, {32'hA1, 32'hA1});
        end
        ex_is_load = 1;
        #2;
        tests++;
        if (fwd_data !== {32'hB2, 32'hB2} || {stall_front, bubble_ex} !== 2'b11) begin
            failed++;
            $display("FAIL prio_mem got %h st/bub=%b%b want %h 11", fwd_data, stall_front, bubble_ex, {32'hB2, 32'hB2});
        end
        id_rren = 2'b00; rf_rdata = {32'h2222, 32'h1111};
        #2;
        tests++;
        if (fwd_data !== {32'h2222, 32'h1111}) begin
            failed++;
            $display("FAIL rren_off got %h want %h", fwd_data, {32'h2222, 32'h1111});
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        set_mem_load(5'd8);
        for (int i = 0; i < 17; i++) tick();
        #2;
        tests++;
        if (err_timeout !== 1'b1) begin
            failed++;
            $display("FAIL rmw_pre got err=%b want 1", err_timeout);
        end
        rst = 0;
        model_clear();
        #1;
        tests++;
        if ({stall_front, bubble_ex, freeze, flush, cnt_stall, cnt_lu, cnt_flush, err_timeout} !== '0) begin
            failed++;
            $display("FAIL rmw_async got ctrl=%b cnt=%0d/%0d/%0d err=%b want all 0",
                     {stall_front, bubble_ex, freeze, flush}, cnt_stall, cnt_lu, cnt_flush, err_timeout);
        end
        @(posedge clk);
        #1;
        idle();
        rst = 1;
        #2;
        tests++;
        if (freeze !== 1'b0 || stall_front !== 1'b0) begin
            failed++;
            $display("FAIL rmw_run got freeze=%b stall=%b want 0/0", freeze, stall_front);
        end
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            id_rs       = {REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3))};
            id_rren     = 2'($urandom_range(0, 3));
            rf_rdata    = {$urandom(), $urandom()};
            ex_valid    = 1'($urandom_range(0, 1));
            mem_valid   = 1'($urandom_range(0, 1));
            wb_valid    = 1'($urandom_range(0, 1));
            ex_wen      = 1'($urandom_range(0, 1));
            mem_wen     = 1'($urandom_range(0, 1));
            wb_wen      = 1'($urandom_range(0, 1));
            ex_is_load  = ($urandom_range(0, 3) == 0);
            mem_is_load = ($urandom_range(0, 2) == 0);
            ex_wr       = REG_AW'($urandom_range(0, 3));
            mem_wr      = REG_AW'($urandom_range(0, 3));
            wb_wr       = REG_AW'($urandom_range(0, 3));
            ex_alu      = $urandom();
            mem_alu     = $urandom();
            mem_dm      = $urandom();
            wb_data     = $urandom();
            dm_rvalid   = ($urandom_range(0, 9) < 6);
            ex_br_taken = ($urandom_range(0, 7) == 0);
            #2;
            tests++;
            if (fwd_data !== exp_fwd()) begin
                failed++;
                $display("FAIL rnd_fwd[%0d] got %h want %h", n, fwd_data, exp_fwd());
            end
            tests++;
            if ({stall_front, bubble_ex, freeze, flush} !== exp_ctrl()) begin
                failed++;
                $display("FAIL rnd_ctrl[%0d] got %b want %b", n, {stall_front, bubble_ex, freeze, flush}, exp_ctrl());
            end
            tests++;
            if ({cnt_stall, cnt_lu, cnt_flush, err_timeout} !== exp_cnts()) begin
                failed++;
                $display("FAIL rnd_cnts[%0d] got %h want %h", n, {cnt_stall, cnt_lu, cnt_flush, err_timeout}, exp_cnts());
            end
            tick();
        end
    endtask

    initial begin
        rst = 0;
        idle();
        model_clear();
        #1;
        test_reset();
        test_forward_ex();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_x0_priority();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
